fwd_hazard_unit: RTL

Parametrised successor to the pipeline forwarding logic. Computes per-source forwarding selects for the EX stage and detects load-use hazards between EX and ID. A small FSM holds a configurable multi-cycle stall with bubble insertion. Also maintains a sticky error flag and a saturating stall-cycle counter. Sits beside the ID/EX pipeline registers and drives their stall/bubble controls plus the EX operand muxes.

---
 rtl/fwd_hazard_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding selects plus load-use hazard detection with a
// programmable multi-cycle stall/bubble sequencer and stall-cycle accounting.
module fwd_hazard_unit #(
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      RUWr_ex,
    input  logic                      is_load_ex,
    input  logic [REG_AW-1:0]         rd_ex,
    input  logic                      RUWr_me,
    input  logic                      is_load_me,
    input  logic [REG_AW-1:0]         rd_me,
    input  logic                      RUWr_wb,
    input  logic [REG_AW-1:0]         rd_wb,
    input  logic [NUM_SRC*REG_AW-1:0] rs_id,
    input  logic [NUM_SRC-1:0]        use_rs_id,
    input  logic [NUM_SRC*REG_AW-1:0] rs_ex,
    output logic [2*NUM_SRC-1:0]      ForwardSrc,
    output logic                      stall_if,
    output logic                      stall_id,
    output logic                      bubble_ex,
    output logic                      hazard_err,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int unsigned DC_W   = $clog2(LOAD_LAT + 1);
    localparam int unsigned RELOAD = (LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DC_W-1:0]   cnt_q, cnt_d;
    logic [NUM_SRC-1:0] hit_me;
    logic [NUM_SRC-1:0] hit_wb;
    logic              load_fwd_err;
    logic              hz;
    logic              stall_c;

    // Per-source forwarding; ME result is newer, so it wins over WB
    always_comb begin
        hit_me     = '0;
        hit_wb     = '0;
        ForwardSrc = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            hit_me[i] = RUWr_me && (rd_me != '0) && (rd_me == rs_ex[i*REG_AW +: REG_AW]);
            hit_wb[i] = RUWr_wb && (rd_wb != '0) && (rd_wb == rs_ex[i*REG_AW +: REG_AW]);
            if (hit_me[i]) begin
                ForwardSrc[2*i +: 2] = 2'b01;
            end else if (hit_wb[i]) begin
                ForwardSrc[2*i +: 2] = 2'b10;
            end
        end
    end

    assign load_fwd_err = (|hit_me) && is_load_me;

    // Load in EX whose destination is consumed by the instruction in ID
    always_comb begin
        hz = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (use_rs_id[i] && (rs_id[i*REG_AW +: REG_AW] == rd_ex)) begin
                hz = 1'b1;
            end
        end
        hz = hz && RUWr_ex && is_load_ex && (rd_ex != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // First stall cycle is spent in IDLE, so STALL covers the remaining LOAD_LAT-1
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (hz && (LOAD_LAT > 1)) begin
                    state_d = STALL;
                    cnt_d   = DC_W'(RELOAD);
                end
            end
            STALL: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - DC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset masks the stall controls immediately, independent of the clock
    always_comb begin
        stall_c = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE:    stall_c = hz;
                STALL:   stall_c = 1'b1;
                default: stall_c = 1'b0;
            endcase
        end
    end

    assign stall_if  = stall_c;
    assign stall_id  = stall_c;
    assign bubble_ex = stall_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hazard_err <= 1'b0;
        end else if (load_fwd_err) begin
            hazard_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_c && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
